dram_cmd_sequencer: RTL

- Sits directly upstream of the DRAM controller. It turns whole-burst host requests into the controller's two-cycle command protocol:
  - command beat, carrying the address and data word 0;
  - second beat, carrying data word 1.
- Gates command launch on dram_ready and on an outstanding-read limit.
- Re-tags the controller's read-return beats as first/last.
- Buffers requests in a small FWFT FIFO.

---
 rtl/dram_cmd_sequencer_pkg.sv | 26 ++
 rtl/dram_cmd_sequencer_if.sv | 41 ++++
 rtl/dram_req_fifo.sv | 61 ++++++
 rtl/dram_cmd_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared types and widths for the DRAM command sequencer slice.
package dram_cmd_sequencer_pkg;

  localparam int BEAT_W     = 144;
  localparam int BE_W       = 18;
  localparam int BURST_W    = 288;
  localparam int BURST_BE_W = 36;
  localparam int ADDR_W     = 30;
  localparam int CMD_ADDR_W = 32;
  localparam int OUT_CNT_W  = 8;

  // One whole-burst host request as stored in the request FIFO.
  typedef struct packed {
    logic                  rnw;
    logic [ADDR_W-1:0]     addr;
    logic [BURST_W-1:0]    data;
    logic [BURST_BE_W-1:0] be;
  } req_t;

  // IDLE holds beat1 (or idle values); CMD presents beat0 with the strobe.
  typedef enum logic {
    IDLE,
    CMD
  } state_t;

endpackage

// File: rtl/dram_cmd_sequencer_if.sv
// Host request/response and DRAM controller signals of the sequencer.
// master is the sequencer side, slave is the host/controller side.
interface dram_cmd_sequencer_if;
  import dram_cmd_sequencer_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rnw;
  logic [ADDR_W-1:0]     req_addr;
  logic [BURST_W-1:0]    req_data;
  logic [BURST_BE_W-1:0] req_be;

  logic [BEAT_W-1:0]     rsp_data;
  logic                  rsp_valid;
  logic                  rsp_last;
  logic [OUT_CNT_W-1:0]  rd_outstanding;

  logic [CMD_ADDR_W-1:0] dram_cmd_addr;
  logic                  dram_cmd_rnw;
  logic                  dram_cmd_valid;
  logic [BEAT_W-1:0]     dram_wr_data;
  logic [BE_W-1:0]       dram_wr_be;
  logic [BEAT_W-1:0]     dram_rd_data;
  logic                  dram_rd_valid;
  logic                  dram_ready;

  modport master (
    input  req_valid, req_rnw, req_addr, req_data, req_be,
    input  dram_rd_data, dram_rd_valid, dram_ready,
    output req_ready, rsp_data, rsp_valid, rsp_last, rd_outstanding,
    output dram_cmd_addr, dram_cmd_rnw, dram_cmd_valid, dram_wr_data, dram_wr_be
  );

  modport slave (
    output req_valid, req_rnw, req_addr, req_data, req_be,
    output dram_rd_data, dram_rd_valid, dram_ready,
    input  req_ready, rsp_data, rsp_valid, rsp_last, rd_outstanding,
    input  dram_cmd_addr, dram_cmd_rnw, dram_cmd_valid, dram_wr_data, dram_wr_be
  );

endinterface

// File: rtl/dram_req_fifo.sv
// First-word-fall-through request FIFO; head is visible whenever not empty.
// A push while full is dropped, even if a pop happens in the same cycle.
module dram_req_fifo
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  req_t data_i,
  input  logic pop_i,
  output req_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  // Entry storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Turns queued whole-burst requests into the controller's two-beat command
// protocol, limits reads in flight and tags read-return beats first/last.
module dram_cmd_sequencer
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH     = 4,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input logic                   dram_clk,
  input logic                   dram_rst_n,
  dram_cmd_sequencer_if.master  bus
);

  req_t                  reqIn;
  req_t                  head;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  rdLimitOk;
  logic                  launch;

  state_t                state_q, state_d;
  logic                  cmdValid_q, cmdValid_d;
  logic [CMD_ADDR_W-1:0] cmdAddr_q, cmdAddr_d;
  logic                  cmdRnw_q, cmdRnw_d;
  logic [BEAT_W-1:0]     wrData_q, wrData_d;
  logic [BE_W-1:0]       wrBe_q, wrBe_d;
  logic [BEAT_W-1:0]     holdData_q, holdData_d;
  logic [BE_W-1:0]       holdBe_q, holdBe_d;

  logic [OUT_CNT_W-1:0]  rdOut_q, rdOut_d;
  logic                  parity_q, parity_d;
  logic                  rspValid_q, rspValid_d;
  logic [BEAT_W-1:0]     rspData_q, rspData_d;
  logic                  rspLast_q, rspLast_d;

  assign reqIn = '{bus.req_rnw, bus.req_addr, bus.req_data, bus.req_be};

  dram_req_fifo #(
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (dram_clk),
    .rst_ni  (dram_rst_n),
    .push_i  (bus.req_valid),
    .data_i  (reqIn),
    .pop_i   (launch),
    .data_o  (head),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign rdLimitOk = (rdOut_q < OUT_CNT_W'(MAX_RD_OUTSTANDING));
  assign launch    = (state_q == IDLE) && !fifoEmpty && bus.dram_ready &&
                     (!head.rnw || rdLimitOk);

  // Next state and command beats: beat0 at launch, held beat1 one cycle later.
  always_comb begin
    state_d    = state_q;
    cmdValid_d = 1'b0;
    cmdAddr_d  = cmdAddr_q;
    cmdRnw_d   = cmdRnw_q;
    wrData_d   = wrData_q;
    wrBe_d     = wrBe_q;
    holdData_d = holdData_q;
    holdBe_d   = holdBe_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d    = CMD;
          cmdValid_d = 1'b1;
          cmdAddr_d  = {head.addr, 2'b00};
          cmdRnw_d   = head.rnw;
          wrData_d   = head.data[BEAT_W-1:0];
          wrBe_d     = head.rnw ? '0 : head.be[BE_W-1:0];
          holdData_d = head.data[BURST_W-1:BEAT_W];
          holdBe_d   = head.rnw ? '0 : head.be[BURST_BE_W-1:BE_W];
        end
      end
      CMD: begin
        state_d  = IDLE;
        wrData_d = holdData_q;
        wrBe_d   = holdBe_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read bookkeeping and the one-cycle response pipeline with first/last tag.
  always_comb begin
    rdOut_d = rdOut_q;
    case ({launch && head.rnw, bus.dram_rd_valid && parity_q})
      2'b10:   rdOut_d = rdOut_q + OUT_CNT_W'(1);
      2'b01:   rdOut_d = rdOut_q - OUT_CNT_W'(1);
      default: rdOut_d = rdOut_q;
    endcase
    parity_d   = parity_q ^ bus.dram_rd_valid;
    rspValid_d = bus.dram_rd_valid;
    rspData_d  = bus.dram_rd_data;
    rspLast_d  = bus.dram_rd_valid && parity_q;
  end

  // FSM state register.
  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command-side output and beat1 holding registers.
  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      cmdValid_q <= 1'b0;
      cmdAddr_q  <= '0;
      cmdRnw_q   <= 1'b0;
      wrData_q   <= '0;
      wrBe_q     <= '0;
      holdData_q <= '0;
      holdBe_q   <= '0;
    end else begin
      cmdValid_q <= cmdValid_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdRnw_q   <= cmdRnw_d;
      wrData_q   <= wrData_d;
      wrBe_q     <= wrBe_d;
      holdData_q <= holdData_d;
      holdBe_q   <= holdBe_d;
    end
  end

  // Response-side registers and outstanding-read counter.
  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      rdOut_q    <= '0;
      parity_q   <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspLast_q  <= 1'b0;
    end else begin
      rdOut_q    <= rdOut_d;
      parity_q   <= parity_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspLast_q  <= rspLast_d;
    end
  end

  assign bus.req_ready      = !fifoFull;
  assign bus.dram_cmd_valid = cmdValid_q;
  assign bus.dram_cmd_addr  = cmdAddr_q;
  assign bus.dram_cmd_rnw   = cmdRnw_q;
  assign bus.dram_wr_data   = wrData_q;
  assign bus.dram_wr_be     = wrBe_q;
  assign bus.rd_outstanding = rdOut_q;
  assign bus.rsp_valid      = rspValid_q;
  assign bus.rsp_data       = rspData_q;
  assign bus.rsp_last       = rspLast_q;

endmodule
